// File: rtl/membrane_integrator_pkg.sv
// membrane_integrator_pkg: neuron FSM state enumeration and membrane width derivation shared with the spike generator
package membrane_integrator_pkg;
   typedef enum logic {INTEGRATE, REFRACTORY} state_t;
   function automatic int mem_width(input int n_stage);
      return n_stage + 2;
   endfunction
endpackage

// File: rtl/membrane_integrator.sv
// membrane_integrator: leaky saturating membrane integrator with spike reset, refractory hold and drop counter (clk, rst_n, en, in_valid, in_current, is_spike -> u, spike_out, refractory, drop_cnt)
module membrane_integrator
   import membrane_integrator_pkg::*;
#(
   parameter int N_STAGE = 2,
   parameter int LEAK_SHIFT = 1,
   parameter int REFRACT_CYCLES = 2,
   localparam int W = mem_width(N_STAGE),
   localparam int CW = REFRACT_CYCLES > 0 ? $clog2(REFRACT_CYCLES + 1) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   input  logic [W-1:0] in_current,
   input  logic         is_spike,
   output logic [W-1:0] u,
   output logic         spike_out,
   output logic         refractory,
   output logic [7:0]   drop_cnt
);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [W-1:0] u_n;
   logic [W:0] sum;
   logic [7:0] drop_cnt_n;
   logic integ, fire, drop, spike_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INTEGRATE;
         cnt <= '0;
         u <= '0;
         spike_out <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         u <= u_n;
         spike_out <= spike_n;
         drop_cnt <= drop_cnt_n;
      end
   end
   always_comb begin
      integ = state == INTEGRATE;
      fire = en & integ & is_spike;
      drop = en & in_valid & (~integ | is_spike);
      sum = {1'b0, u} - {1'b0, u >> LEAK_SHIFT} + {1'b0, in_valid ? in_current : {W{1'b0}}};
      u_n = !en ? u : (!integ || is_spike) ? '0 : (sum[W] ? '1 : sum[W-1:0]);
      spike_n = fire;
      state_n = (fire && REFRACT_CYCLES != 0) ? REFRACTORY
              : (en && !integ && cnt == CW'(1)) ? INTEGRATE : state;
      cnt_n = fire ? CW'(REFRACT_CYCLES) : (en && !integ) ? cnt - CW'(1) : cnt;
      drop_cnt_n = drop_cnt + 8'(drop && drop_cnt != 8'hff);
      refractory = state == REFRACTORY;
   end
endmodule
